nfc_data_out_sequencer: RTL

- Sequences one NAND DDR data-out (read) burst through the physical input capture path.
- Per accepted command it runs four steps in order:
  - optional DQS delay-tap load;
  - capture-buffer reset;
  - the RE toggle window plus the time-aligned capture write-enable window;
  - drain monitoring until the streamed last beat.
- Sits between the channel command engine and the physical input and output PHYs; the sole driver of capture-buffer control.

---
 rtl/nfc_pkg.sv | 20 ++
 rtl/nfc_data_out_sequencer_if.sv | 21 ++
 rtl/nfc_seq_window_delay.sv | 25 ++
 rtl/nfc_data_out_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/nfc_pkg.sv
// nfc_pkg: shared state encoding and constants for the
// NAND DDR data-out sequencer.
package nfc_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_TAPLOAD   = 4'd1,
      ST_TAPWAIT   = 4'd2,
      ST_BUFRST    = 4'd3,
      ST_PREAMBLE  = 4'd4,
      ST_BURST     = 4'd5,
      ST_POSTAMBLE = 4'd6,
      ST_DRAIN     = 4'd7,
      ST_ABORT     = 4'd8,
      ST_DONE      = 4'd9
   } seq_state_t;

   localparam int CAPTURE_ALE_BIT = 0;

endpackage

// File: rtl/nfc_data_out_sequencer_if.sv
// Command handshake between the channel command engine
// and the data-out sequencer.
interface nfc_data_out_sequencer_if #(
   parameter int BurstWidth = 16
);
   logic                  iCmdValid;
   logic                  oCmdReady;
   logic [BurstWidth-1:0] iByteCount;
   logic                  iTapChange;
   logic [4:0]            iDelayTap;

   modport master (
      output iCmdValid, iByteCount, iTapChange, iDelayTap,
      input  oCmdReady
   );

   modport slave (
      input  iCmdValid, iByteCount, iTapChange, iDelayTap,
      output oCmdReady
   );
endinterface

// File: rtl/nfc_seq_window_delay.sv
// Fixed-depth shift register that delays the RE toggle
// window into the capture write-enable window.
module nfc_seq_window_delay #(
   parameter int Depth = 3
) (
   input  logic iSystemClock,
   input  logic iModuleReset,
   input  logic iFlush,
   input  logic iWindow,
   output logic oWindow
);
   logic [Depth-1:0] stages;

   always_ff @(posedge iSystemClock or negedge iModuleReset) begin
      if (!iModuleReset) begin
         stages <= '0;
      end else if (iFlush) begin
         stages <= '0;
      end else begin
         stages <= (stages << 1) | Depth'(iWindow);
      end
   end

   assign oWindow = stages[Depth-1];
endmodule

// File: rtl/nfc_data_out_sequencer.sv
// Sequences one DDR data-out burst: tap load, capture-buffer
// reset, RE toggling with aligned capture window, and drain.
module nfc_data_out_sequencer
   import nfc_pkg::*;
#(
   parameter int BurstWidth      = 16,
   parameter int BufResetCycles  = 4,
   parameter int PreambleCycles  = 2,
   parameter int PostambleCycles = 2,
   parameter int CaptureDelay    = 3,
   parameter int DrainTimeout    = 1024
) (
   input  logic       iSystemClock,
   input  logic       iModuleReset,
   nfc_data_out_sequencer_if.slave cmd,
   input  logic       iAbort,
   output logic       oPI_DelayTapLoad,
   output logic [4:0] oPI_DelayTap,
   input  logic       iPI_DelayReady,
   output logic       oPI_BuffReset,
   output logic       oPI_Buff_WE,
   output logic [3:0] oAddressLatchEnable,
   output logic       oREToggle,
   output logic       oREHold,
   input  logic       iPI_Buff_Empty,
   input  logic       iPI_Buff_Valid,
   input  logic       iPI_Buff_Ready,
   input  logic       iPI_Buff_Last,
   output logic       oBusy,
   output logic       oDone,
   output logic       oError
);
   typedef logic [BurstWidth-1:0] cnt_t;

   // Postamble must cover the tail of the delayed capture window.
   localparam int PostLen =
      (PostambleCycles > CaptureDelay) ? PostambleCycles : CaptureDelay;
   localparam int TmoW = $clog2(DrainTimeout + 1);

   localparam cnt_t CntMax   = '1;
   localparam cnt_t BufLast  = cnt_t'(BufResetCycles - 1);
   localparam cnt_t BufGap   = cnt_t'(BufResetCycles);
   localparam cnt_t PreLast  = cnt_t'(PreambleCycles - 1);
   localparam cnt_t PostLast = cnt_t'(PostLen - 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(DrainTimeout - 1);
   localparam logic [TmoW-1:0] TmoMax  = '1;

   seq_state_t      state, nextState;
   cnt_t            cnt, beats, accCnt, reqBeats;
   logic [TmoW-1:0] tmo;
   logic            errFlag;
   logic            accept, abortTake, beatTake, lastBeat;
   logic            winOut;
   logic            unusedEmpty;

   assign unusedEmpty = iPI_Buff_Empty;
   assign accept      = cmd.iCmdValid && (state == ST_IDLE);
   assign reqBeats    = cnt_t'(cmd.iByteCount >> 1)
                      + cnt_t'(cmd.iByteCount[0]);
   assign beatTake    = iPI_Buff_Valid && iPI_Buff_Ready;
   assign lastBeat    = beatTake && iPI_Buff_Last;
   assign abortTake   = iAbort && (state != ST_IDLE)
                      && (state != ST_DONE) && (state != ST_ABORT);

   always_comb begin
      nextState = state;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               if (cmd.iByteCount == '0)  nextState = ST_DONE;
               else if (cmd.iTapChange)   nextState = ST_TAPLOAD;
               else                       nextState = ST_BUFRST;
            end
         end
         ST_TAPLOAD:   nextState = ST_TAPWAIT;
         ST_TAPWAIT:   if (iPI_DelayReady) nextState = ST_BUFRST;
         ST_BUFRST:    if (cnt == BufGap) nextState = ST_PREAMBLE;
         ST_PREAMBLE:  if (cnt == PreLast) nextState = ST_BURST;
         ST_BURST:     if (cnt == beats - 1'b1) nextState = ST_POSTAMBLE;
         ST_POSTAMBLE: if (cnt == PostLast) nextState = ST_DRAIN;
         ST_DRAIN: begin
            if (lastBeat)            nextState = ST_DONE;
            else if (tmo == TmoLast) nextState = ST_ABORT;
         end
         ST_ABORT:     if (cnt == BufLast) nextState = ST_DONE;
         ST_DONE:      nextState = ST_IDLE;
         default:      nextState = ST_IDLE;
      endcase
      if (abortTake) nextState = ST_ABORT;
   end

   always_ff @(posedge iSystemClock or negedge iModuleReset) begin
      if (!iModuleReset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         beats        <= '0;
         accCnt       <= '0;
         tmo          <= '0;
         errFlag      <= 1'b0;
         oPI_DelayTap <= '0;
      end else begin
         state <= nextState;
         if (nextState != state) cnt <= '0;
         else if (cnt != CntMax) cnt <= cnt + 1'b1;
         if (accept) begin
            beats <= reqBeats;
            if (cmd.iTapChange) oPI_DelayTap <= cmd.iDelayTap;
         end
         if (state != ST_DRAIN) begin
            accCnt <= '0;
            tmo    <= '0;
         end else begin
            if (tmo != TmoMax) tmo <= tmo + 1'b1;
            if (beatTake && accCnt != CntMax) accCnt <= accCnt + 1'b1;
         end
         if (nextState == ST_DONE && state != ST_DONE) begin
            errFlag <= (state == ST_ABORT)
                    || ((state == ST_DRAIN)
                        && (({1'b0, accCnt} + 1'b1) != {1'b0, beats}));
         end
      end
   end

   nfc_seq_window_delay #(
      .Depth (CaptureDelay)
   ) u_window_delay (
      .iSystemClock (iSystemClock),
      .iModuleReset (iModuleReset),
      .iFlush       (abortTake),
      .iWindow      (state == ST_BURST),
      .oWindow      (winOut)
   );

   // Abort gates the PHY strobes in the very cycle it arrives.
   assign oREToggle        = (state == ST_BURST) && !abortTake;
   assign oREHold          = (state == ST_PREAMBLE) && !abortTake;
   assign oPI_Buff_WE      = winOut && !abortTake;
   assign oPI_DelayTapLoad = (state == ST_TAPLOAD);
   assign oPI_BuffReset    = ((state == ST_BUFRST) && (cnt < BufGap))
                          || (state == ST_ABORT);
   assign cmd.oCmdReady    = (state == ST_IDLE);
   assign oBusy            = (state != ST_IDLE);
   assign oDone            = (state == ST_DONE);
   assign oError           = (state == ST_DONE) && errFlag;

   always_comb begin
      oAddressLatchEnable = '0;
      oAddressLatchEnable[CAPTURE_ALE_BIT] = oPI_Buff_WE;
   end
endmodule
